// File: rtl/vregs_multi.sv
// vregs_multi: vector register file with two whole-vector read ports, one
// element read port, a lane-masked vector write port, an element write port
// and a sequenced bulk-clear engine that zeroes one register per cycle.
module vregs_multi #(
  parameter int NREGS  = 16,
  parameter int NLANES = 16,
  parameter int LANE_W = 16,
  parameter int AW     = $clog2(NREGS),
  parameter int IW     = $clog2(NLANES),
  parameter int LW     = $clog2(NLANES) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [AW-1:0]            rAddr0,
  output logic [NLANES*LANE_W-1:0] rData0,
  output logic [LW-1:0]            rLen0,
  input  logic [AW-1:0]            rAddr1,
  output logic [NLANES*LANE_W-1:0] rData1,
  output logic [LW-1:0]            rLen1,
  input  logic [AW-1:0]            rAddr2,
  input  logic [IW-1:0]            rInd2,
  output logic [LANE_W-1:0]        rData2,
  input  logic                     wEn,
  input  logic [AW-1:0]            wAddr,
  input  logic [NLANES-1:0]        wMask,
  input  logic [NLANES*LANE_W-1:0] wData,
  input  logic                     wLenEn,
  input  logic [LW-1:0]            wLen,
  input  logic                     eEn,
  input  logic [AW-1:0]            eAddr,
  input  logic [IW-1:0]            eInd,
  input  logic [LANE_W-1:0]        eData,
  input  logic                     clrReq,
  output logic                     clrBusy,
  output logic                     clrDone
);

  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

  localparam logic [LW-1:0] MAX_LEN  = LW'(NLANES);
  localparam logic [AW-1:0] LAST_REG = AW'(NREGS - 1);

  state_t            state;
  state_t            state_next;
  logic [AW-1:0]     ptr;
  logic [AW-1:0]     ptr_next;
  logic              done_q;
  logic              done_next;
  logic              sweeping;

  logic [LANE_W-1:0] mem [NREGS][NLANES];
  logic [LW-1:0]     len [NREGS];

  assign sweeping = (state == SWEEP);
  assign clrBusy  = sweeping;
  assign clrDone  = done_q;

  // Clear sequencer next-state: walk ptr across every register once, pulse done on the last.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (clrReq) begin
          state_next = SWEEP;
          ptr_next   = '0;
        end
      end
      SWEEP: begin
        ptr_next = ptr + AW'(1);
        if (ptr == LAST_REG) begin
          state_next = IDLE;
          ptr_next   = '0;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        ptr_next   = '0;
      end
    endcase
  end

  // Clear sequencer registers; reset abandons any sweep without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      ptr    <= ptr_next;
      done_q <= done_next;
    end
  end

  // Register storage: sweep zeroing locks out both write ports; element write lands last so it wins a lane collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        len[r] <= '0;
        for (int l = 0; l < NLANES; l++) begin
          mem[r][l] <= '0;
        end
      end
    end else if (sweeping) begin
      len[ptr] <= '0;
      for (int l = 0; l < NLANES; l++) begin
        mem[ptr][l] <= '0;
      end
    end else begin
      if (wEn) begin
        for (int l = 0; l < NLANES; l++) begin
          if (wMask[l]) begin
            mem[wAddr][l] <= wData[l*LANE_W +: LANE_W];
          end
        end
        if (wLenEn) begin
          len[wAddr] <= (wLen > MAX_LEN) ? MAX_LEN : wLen;
        end
      end
      if (eEn) begin
        mem[eAddr][eInd] <= eData;
      end
    end
  end

  // Combinational read ports straight from stored state, no write forwarding.
  always_comb begin
    rData0 = '0;
    rData1 = '0;
    for (int l = 0; l < NLANES; l++) begin
      rData0[l*LANE_W +: LANE_W] = mem[rAddr0][l];
      rData1[l*LANE_W +: LANE_W] = mem[rAddr1][l];
    end
    rLen0  = len[rAddr0];
    rLen1  = len[rAddr1];
    rData2 = mem[rAddr2][rInd2];
  end

endmodule

// File: tb/tb_vregs_multi.sv
// tb_vregs_multi: directed stimulus for vregs_multi, checked every cycle
// against a behavioural model plus a set of hand-computed literal checks.
module tb_vregs_multi;

  localparam int NREGS  = 16;
  localparam int NLANES = 16;
  localparam int LANE_W = 16;
  localparam int AW     = 4;
  localparam int IW     = 4;
  localparam int LW     = 5;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [AW-1:0]            rAddr0, rAddr1, rAddr2;
  logic [IW-1:0]            rInd2;
  logic [NLANES*LANE_W-1:0] rData0, rData1;
  logic [LW-1:0]            rLen0, rLen1;
  logic [LANE_W-1:0]        rData2;
  logic                     wEn, wLenEn, eEn, clrReq;
  logic [AW-1:0]            wAddr, eAddr;
  logic [NLANES-1:0]        wMask;
  logic [NLANES*LANE_W-1:0] wData;
  logic [LW-1:0]            wLen;
  logic [IW-1:0]            eInd;
  logic [LANE_W-1:0]        eData;
  logic                     clrBusy, clrDone;

  vregs_multi dut (
    .clk(clk), .reset(reset),
    .rAddr0(rAddr0), .rData0(rData0), .rLen0(rLen0),
    .rAddr1(rAddr1), .rData1(rData1), .rLen1(rLen1),
    .rAddr2(rAddr2), .rInd2(rInd2), .rData2(rData2),
    .wEn(wEn), .wAddr(wAddr), .wMask(wMask), .wData(wData),
    .wLenEn(wLenEn), .wLen(wLen),
    .eEn(eEn), .eAddr(eAddr), .eInd(eInd), .eData(eData),
    .clrReq(clrReq), .clrBusy(clrBusy), .clrDone(clrDone)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: plain arrays; the clear is described by the edge at which it was accepted.
  logic [LANE_W-1:0] m_mem [NREGS][NLANES];
  logic [LW-1:0]     m_len [NREGS];
  int                edge_n = 0;
  int                sweep_start = -1;
  int                k_sw;
  bit                in_sw;
  bit                m_busy = 1'b0;
  bit                m_done = 1'b0;
  bit                model_ok = 1'b0;
  logic [NLANES*LANE_W-1:0] exp0, exp1;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idleInputs();
    wEn = 1'b0; wAddr = '0; wMask = '0; wData = '0; wLenEn = 1'b0; wLen = '0;
    eEn = 1'b0; eAddr = '0; eInd = '0; eData = '0; clrReq = 1'b0;
  endtask

  // Model update on each rising edge, using the inputs held stable across that edge.
  always @(posedge clk) begin
    edge_n++;
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        m_len[r] = '0;
        for (int l = 0; l < NLANES; l++) m_mem[r][l] = '0;
      end
      sweep_start = -1;
      m_busy = 1'b0;
      m_done = 1'b0;
      model_ok = 1'b1;
    end else begin
      in_sw = (sweep_start >= 0) && (edge_n > sweep_start) && (edge_n <= sweep_start + NREGS);
      if (in_sw) begin
        k_sw = edge_n - sweep_start - 1;
        m_len[k_sw] = '0;
        for (int l = 0; l < NLANES; l++) m_mem[k_sw][l] = '0;
        m_done = (k_sw == NREGS - 1);
      end else begin
        m_done = 1'b0;
        if (wEn) begin
          for (int l = 0; l < NLANES; l++)
            if (wMask[l]) m_mem[wAddr][l] = wData[l*LANE_W +: LANE_W];
          if (wLenEn) m_len[wAddr] = (int'(wLen) > NLANES) ? LW'(NLANES) : wLen;
        end
        if (eEn) m_mem[eAddr][eInd] = eData;
        if (clrReq) sweep_start = edge_n;
      end
      m_busy = (sweep_start >= 0) && (edge_n >= sweep_start) && (edge_n < sweep_start + NREGS);
    end
  end

  // Compare every DUT output against the model mid-cycle.
  always @(negedge clk) begin
    if (model_ok) begin
      for (int l = 0; l < NLANES; l++) begin
        exp0[l*LANE_W +: LANE_W] = m_mem[rAddr0][l];
        exp1[l*LANE_W +: LANE_W] = m_mem[rAddr1][l];
      end
      checkOutput("rData0", rData0, exp0);
      checkOutput("rLen0", rLen0, m_len[rAddr0]);
      checkOutput("rData1", rData1, exp1);
      checkOutput("rLen1", rLen1, m_len[rAddr1]);
      checkOutput("rData2", rData2, m_mem[rAddr2][rInd2]);
      checkOutput("clrBusy", clrBusy, m_busy);
      checkOutput("clrDone", clrDone, m_done);
    end
  end

  int busy_cnt, done_cnt, done_at;

  // Directed stimulus sequence with literal expectations.
  initial begin
    reset = 1'b1;
    idleInputs();
    rAddr0 = '0; rAddr1 = '0; rAddr2 = '0; rInd2 = '0;
    applyStimulus(2);
    reset = 1'b0;
    checkOutput("rst_busy", clrBusy, 0);
    checkOutput("rst_done", clrDone, 0);
    checkOutput("rst_data0", rData0, 0);
    checkOutput("rst_len0", rLen0, 0);
    for (int a = 0; a < NREGS; a++) begin
      rAddr0 = AW'(a); rAddr1 = AW'(NREGS - 1 - a); rAddr2 = AW'(a); rInd2 = IW'(a);
      applyStimulus(1);
    end

    // masked vector write with length
    wEn = 1'b1; wAddr = 4'd3; wMask = 16'h00FF; wLenEn = 1'b1; wLen = 5'd8;
    for (int l = 0; l < NLANES; l++) wData[l*LANE_W +: LANE_W] = 16'(16'h0100 + l);
    rAddr0 = 4'd3;
    #1;
    checkOutput("same_cycle_lane0", rData0[15:0], 0);
    checkOutput("same_cycle_len", rLen0, 0);
    applyStimulus(1);
    idleInputs();
    #1;
    checkOutput("wr_lane0", rData0[15:0], 16'h0100);
    checkOutput("wr_lane7", rData0[127:112], 16'h0107);
    checkOutput("wr_lane8", rData0[143:128], 16'h0000);
    checkOutput("wr_len", rLen0, 8);

    // length saturates at NLANES
    wEn = 1'b1; wAddr = 4'd3; wMask = '0; wLenEn = 1'b1; wLen = 5'd20; rAddr1 = 4'd3;
    applyStimulus(1);
    idleInputs();
    #1;
    checkOutput("len_clamp", rLen1, 16);

    // vector and element write to the same lane: element wins
    wEn = 1'b1; wAddr = 4'd5; wMask = 16'hFFFF; wData = {16{16'hAAAA}};
    eEn = 1'b1; eAddr = 4'd5; eInd = 4'd2; eData = 16'h1234;
    applyStimulus(1);
    idleInputs();
    rAddr2 = 4'd5; rInd2 = 4'd2; rAddr0 = 4'd5;
    #1;
    checkOutput("coll_elem", rData2, 16'h1234);
    checkOutput("coll_lane1", rData0[31:16], 16'hAAAA);
    checkOutput("coll_lane2", rData0[47:32], 16'h1234);

    // fill every register with nonzero data and lengths
    for (int r = 0; r < NREGS; r++) begin
      wEn = 1'b1; wAddr = AW'(r); wMask = 16'hFFFF; wLenEn = 1'b1; wLen = LW'(r + 1);
      for (int l = 0; l < NLANES; l++) wData[l*LANE_W +: LANE_W] = 16'(r * 256 + l * 16 + 5);
      eEn = 1'b1; eAddr = AW'((r + 7) % NREGS); eInd = IW'(r); eData = 16'(16'h1000 + r * 17);
      rAddr0 = AW'(r); rAddr1 = AW'((r + 7) % NREGS); rAddr2 = AW'(r); rInd2 = IW'(15 - r);
      applyStimulus(1);
    end
    idleInputs();

    // bulk clear with dropped writes, ignored re-request, write in the done cycle
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    clrReq = 1'b1;
    applyStimulus(1);
    clrReq = 1'b0;
    for (int j = 0; j < 20; j++) begin
      if (clrBusy) busy_cnt++;
      if (clrDone) begin
        done_cnt++;
        done_at = j;
      end
      idleInputs();
      rAddr0 = AW'(j % NREGS); rAddr1 = AW'((j + 15) % NREGS);
      rAddr2 = 4'd15; rInd2 = IW'(j % NLANES);
      if (j < 10) begin
        wEn = 1'b1; wAddr = 4'd15; wMask = 16'hFFFF; wData = {16{16'hFFFF}};
        wLenEn = 1'b1; wLen = 5'd3;
        eEn = 1'b1; eAddr = 4'd14; eInd = 4'd0; eData = 16'hDEAD;
      end
      if (j == 6) clrReq = 1'b1;
      if (j == 16) begin
        wEn = 1'b1; wAddr = 4'd2; wMask = 16'h0001; wData = '0; wData[15:0] = 16'hBEEF;
      end
      applyStimulus(1);
    end
    idleInputs();
    rAddr0 = 4'd2; rAddr1 = 4'd15; rAddr2 = 4'd14; rInd2 = 4'd0;
    #1;
    checkOutput("clr_busy_cycles", busy_cnt, 16);
    checkOutput("clr_done_pulses", done_cnt, 1);
    checkOutput("clr_done_cycle", done_at, 16);
    checkOutput("done_cycle_write", rData0[15:0], 16'hBEEF);
    checkOutput("swept_lane1", rData0[31:16], 16'h0000);
    checkOutput("dropped_vec_write", rData1[15:0], 16'h0000);
    checkOutput("dropped_len_write", rLen1, 0);
    checkOutput("dropped_elem_write", rData2, 16'h0000);

    // refill, start a clear, then reset in the middle of the sweep
    for (int r = 0; r < NREGS; r++) begin
      wEn = 1'b1; wAddr = AW'(r); wMask = 16'hFFFF; wLenEn = 1'b1; wLen = 5'd9;
      wData = {16{16'(16'h7700 + r)}};
      applyStimulus(1);
    end
    idleInputs();
    clrReq = 1'b1;
    applyStimulus(1);
    clrReq = 1'b0;
    rAddr0 = 4'd12; rAddr1 = 4'd1;
    applyStimulus(5);
    checkOutput("mid_sweep_busy", clrBusy, 1);
    checkOutput("mid_sweep_unswept", rData0[15:0], 16'h770C);
    reset = 1'b1;
    applyStimulus(1);
    reset = 1'b0;
    checkOutput("abort_busy", clrBusy, 0);
    checkOutput("abort_data", rData0, 0);
    checkOutput("abort_len", rLen0, 0);
    done_cnt = 0;
    for (int j = 0; j < 20; j++) begin
      if (clrDone) done_cnt++;
      rAddr0 = AW'(j % NREGS);
      applyStimulus(1);
    end
    checkOutput("abort_no_done", done_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
